// File: rtl/pcm_playback_feeder.sv
// Stereo sample FIFO feeding the codec playback bus; the presented pair only changes on a codec frame.
// Optional PCM_HOLD_LAST_EN: repeat the last played pair on underrun / while priming instead of 0/0.
module pcm_playback_feeder #(
  parameter int DEPTH       = 8,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            in_left,
  input  logic [15:0]            in_right,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   pcm_accept,
  output logic [15:0]            pcm_left,
  output logic [15:0]            pcm_right,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [15:0]            underrun_count,
  output logic                   playing
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
  localparam logic [CW-1:0] PRIME_LVL = CW'(PRIME_LEVEL);

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic          accept_q;
  logic          frame;
  logic [15:0]   hold_l, hold_r;
  logic [15:0]   next_l, next_r;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          fifo_empty;
  logic          push, pop, underrun;

  // Handshake: a sample moves in on in_valid & in_ready; the codec consumes
  // one pair per rising edge of pcm_accept (a frame). Frames during reset are ignored.
  assign frame      = pcm_accept & ~accept_q & ~reset;
  assign fifo_empty = (fifo_count == '0);
  assign in_ready   = (fifo_count != FULL_LVL);
  assign push       = in_valid & in_ready;
  assign playing    = (state == ST_RUN);

  // The new pair reaches the codec combinationally in its latch cycle only.
  assign pcm_left  = frame ? next_l : hold_l;
  assign pcm_right = frame ? next_r : hold_r;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    underrun  = 1'b0;
`ifdef PCM_HOLD_LAST_EN
    next_l    = hold_l;
    next_r    = hold_r;
`else
    next_l    = '0;
    next_r    = '0;
`endif
    case (state)
      ST_PRIME: begin
        if (fifo_count >= PRIME_LVL) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (frame) begin
          if (!fifo_empty) begin
            {next_l, next_r} = mem[rd_ptr];
            pop              = 1'b1;
          end else begin
            underrun  = 1'b1;
            state_nxt = ST_PRIME;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_PRIME;
      accept_q       <= 1'b1;
      hold_l         <= '0;
      hold_r         <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      underrun_count <= '0;
    end else begin
      state    <= state_nxt;
      accept_q <= pcm_accept;
      if (frame) begin
        hold_l <= next_l;
        hold_r <= next_r;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (underrun && underrun_count != 16'hFFFF)
        underrun_count <= underrun_count + 1'b1;
    end
  end

  // Storage is not reset; clearing the pointers discards its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_left, in_right};
  end

endmodule

// File: tb/tb_pcm_playback_feeder.sv
// Self-checking bench for pcm_playback_feeder: directed scenarios plus a random phase,
// all checked every cycle against a queue-based model of the playback rules.
module tb_pcm_playback_feeder;
  localparam int DEPTH       = 8;
  localparam int PRIME_LEVEL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_left = '0, in_right = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        pcm_accept = 1'b0;
  logic [15:0] pcm_left, pcm_right;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [15:0] underrun_count;
  logic        playing;

  pcm_playback_feeder #(.DEPTH(DEPTH), .PRIME_LEVEL(PRIME_LEVEL)) dut (
    .clk(clk), .reset(reset),
    .in_left(in_left), .in_right(in_right), .in_valid(in_valid), .in_ready(in_ready),
    .pcm_accept(pcm_accept), .pcm_left(pcm_left), .pcm_right(pcm_right),
    .fifo_count(fifo_count), .underrun_count(underrun_count), .playing(playing)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: queue of pending pairs, playing flag, last presented pair.
  logic [31:0] exp_q[$];
  bit          m_run;
  logic [31:0] m_hold;
  bit          m_acc_q;
  int          m_under;

  bit          dir_en = 1'b0;
  logic [31:0] dir_pair;

  task automatic model_reset();
    exp_q.delete();
    m_run   = 1'b0;
    m_hold  = '0;
    m_acc_q = 1'b1;
    m_under = 0;
  endtask

  task automatic cycle();
    bit          frame;
    bit          do_push;
    logic [31:0] nxt;
    logic [31:0] shown;
    @(negedge clk);
    frame = pcm_accept && !m_acc_q && !reset;
`ifdef PCM_HOLD_LAST_EN
    nxt = m_hold;
`else
    nxt = '0;
`endif
    if (m_run && exp_q.size() > 0) nxt = exp_q[0];
    shown = frame ? nxt : m_hold;
    chk("pcm_pair",       {pcm_left, pcm_right}, shown);
    chk("in_ready",       32'(in_ready),        32'(exp_q.size() != DEPTH));
    chk("fifo_count",     32'(fifo_count),      32'(exp_q.size()));
    chk("underrun_count", 32'(underrun_count),  32'(m_under));
    chk("playing",        32'(playing),         32'(m_run));
    if (dir_en) begin
      chk("frame_pair", {pcm_left, pcm_right}, dir_pair);
      dir_en = 1'b0;
    end
    do_push = in_valid && (exp_q.size() != DEPTH);
    if (reset) begin
      model_reset();
    end else begin
      if (frame) m_hold = nxt;
      if (!m_run) begin
        if (exp_q.size() >= PRIME_LEVEL) m_run = 1'b1;
      end else if (frame) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        else begin
          m_run = 1'b0;
          if (m_under < 65535) m_under++;
        end
      end
      if (do_push) exp_q.push_back({in_left, in_right});
      m_acc_q = pcm_accept;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    bit taken;
    taken    = 1'b0;
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
    for (int k = 0; k < 40 && !taken; k++) begin
      taken = (exp_q.size() != DEPTH);
      cycle();
    end
    in_valid = 1'b0;
    if (!taken) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic frame_pulse();
    pcm_accept = 1'b1;
    cycle();
    pcm_accept = 1'b0;
    cycle();
  endtask

  task automatic frame_expect(input logic [31:0] pair);
    dir_en   = 1'b1;
    dir_pair = pair;
    frame_pulse();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    idle(n);
    reset = 1'b0;
  endtask

  int pct;
  int dwell;

  initial begin
    // Reset and idle with a period-32 strobe.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      pcm_accept = ((i % 32) >= 16);
      cycle();
    end
    pcm_accept = 1'b0;
    chk("idle_pcm",     {pcm_left, pcm_right}, 32'h0);
    chk("idle_playing", 32'(playing),          32'd0);
    chk("idle_ready",   32'(in_ready),         32'd1);
    chk("idle_count",   32'(fifo_count),       32'd0);

    // Priming.
    push_pair(16'h0101, 16'h0202);
    push_pair(16'h0303, 16'h0404);
    push_pair(16'h0505, 16'h0606);
    push_pair(16'h0707, 16'h0808);
    idle(1);
    chk("prime_playing", 32'(playing), 32'd1);
    frame_expect(32'h0101_0202);
    idle(2);
    frame_expect(32'h0303_0404);
    frame_expect(32'h0505_0606);
    chk("prime_count", 32'(fifo_count), 32'd1);

    // Backpressure.
    do_reset(2);
    for (int k = 1; k <= 8; k++) push_pair(16'(16'h1000 + k), 16'(16'h2000 + k));
    chk("bp_ready_low", 32'(in_ready),   32'd0);
    chk("bp_count_full", 32'(fifo_count), 32'd8);
    in_valid = 1'b1;
    in_left  = 16'h1009;
    in_right = 16'h2009;
    idle(3);
    chk("bp_hold_count", 32'(fifo_count), 32'd8);
    dir_en = 1'b1;
    dir_pair = 32'h1001_2001;
    frame_pulse();
    in_valid = 1'b0;
    chk("bp_retry_count", 32'(fifo_count), 32'd8);
    frame_pulse();
    push_pair(16'h100A, 16'h200A);
    for (int k = 3; k <= 10; k++) frame_expect({16'(16'h1000 + k), 16'(16'h2000 + k)});

    // Underrun.
    do_reset(2);
    for (int k = 0; k < 4; k++) push_pair(16'(16'h3000 + k), 16'(16'h4000 + k));
    idle(2);
    frame_pulse();
    frame_pulse();
    frame_pulse();
    frame_expect(32'h3003_4003);
`ifdef PCM_HOLD_LAST_EN
    frame_expect(32'h3003_4003);
`else
    frame_expect(32'h0);
`endif
    chk("ur_count",   32'(underrun_count), 32'd1);
    chk("ur_playing", 32'(playing),        32'd0);
    chk("ur_fifo",    32'(fifo_count),     32'd0);

    // Reset mid-run with 5 entries.
    for (int k = 0; k < 5; k++) push_pair(16'(16'h5000 + k), 16'(16'h6000 + k));
    idle(1);
    chk("rst_pre_playing", 32'(playing), 32'd1);
    reset = 1'b1;
    pcm_accept = 1'b1;
    cycle();
    reset = 1'b0;
    pcm_accept = 1'b0;
    chk("rst_count",   32'(fifo_count),          32'd0);
    chk("rst_pcm",     {pcm_left, pcm_right},    32'h0);
    chk("rst_playing", 32'(playing),             32'd0);
    chk("rst_under",   32'(underrun_count),      32'd0);
    idle(2);

    // Simultaneous push and pop.
    for (int k = 0; k < 4; k++) push_pair(16'(16'h7000 + k), 16'(16'h8000 + k));
    idle(2);
    frame_pulse();
    frame_pulse();
    in_valid   = 1'b1;
    in_left    = 16'h7004;
    in_right   = 16'h8004;
    pcm_accept = 1'b1;
    dir_en     = 1'b1;
    dir_pair   = 32'h7002_8002;
    cycle();
    in_valid   = 1'b0;
    pcm_accept = 1'b0;
    chk("pp_count", 32'(fifo_count), 32'd2);
    cycle();
    frame_expect(32'h7003_8003);
    frame_expect(32'h7004_8004);

    // Random phase.
    dwell = 1;
    pct   = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) pct = $urandom_range(10, 90);
      dwell--;
      if (dwell == 0) begin
        pcm_accept = ~pcm_accept;
        dwell = $urandom_range(1, 6);
      end
      in_valid = ($urandom_range(0, 99) < pct);
      in_left  = 16'($urandom);
      in_right = 16'($urandom);
      reset    = ($urandom_range(0, 499) == 0);
      cycle();
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
